// File: rtl/axi_id_remap_pkg.sv
// Shared configuration, slot record and lookup helpers for the AXI ID remapper.
package axi_id_remap_pkg;

  localparam int SlvIdWidth   = 8;
  localparam int MstIdWidth   = 4;
  localparam int NumSlots     = 16;
  localparam int MaxTxnsPerId = 8;
  localparam int CntWidth     = $clog2(MaxTxnsPerId + 1);
  localparam int IdxWidth     = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  typedef logic [IdxWidth-1:0] idx_t;

  typedef struct packed {
    logic                  valid;
    logic [SlvIdWidth-1:0] slv_id;
    logic [CntWidth-1:0]   cnt;
  } slot_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // Scanning downwards lets the lowest matching index win.
  function automatic pick_t first_free(input slot_t tbl [NumSlots]);
    pick_t res;
    res = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!tbl[i].valid) res = '{found: 1'b1, idx: idx_t'(i)};
    end
    return res;
  endfunction

  function automatic pick_t id_match(input slot_t tbl [NumSlots],
                                     input logic [SlvIdWidth-1:0] id);
    pick_t res;
    res = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].slv_id == id) res = '{found: 1'b1, idx: idx_t'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_id_remap_table.sv
// One direction's mapping table: allocates a narrow ID per request and restores the
// wide ID on responses, counting outstanding transactions per slot.
module axi_id_remap_table
  import axi_id_remap_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ax_valid_i,
  input  logic                  ax_ready_i,
  input  logic [SlvIdWidth-1:0] ax_id_i,
  output logic                  stall_o,
  output logic [MstIdWidth-1:0] mst_id_o,
  input  logic                  retire_i,
  input  logic [MstIdWidth-1:0] retire_id_i,
  output logic [SlvIdWidth-1:0] slv_id_o,
  output logic                  empty_o
);

  slot_t r_tbl     [NumSlots];
  slot_t w_nextTbl [NumSlots];
  logic  r_pending;
  idx_t  r_heldIdx;

  pick_t w_hit;
  pick_t w_free;
  idx_t  w_selIdx;
  idx_t  w_retIdx;
  slot_t w_heldSlot;
  slot_t w_retSlot;
  logic  w_stall;
  logic  w_noSlot;
  logic  w_hs;
  logic  w_retOk;
  logic  w_retInRange;

  assign w_hit      = id_match(r_tbl, ax_id_i);
  assign w_free     = first_free(r_tbl);
  assign w_heldSlot = r_tbl[r_heldIdx];
  assign w_retIdx   = retire_id_i[IdxWidth-1:0];
  assign w_retSlot  = r_tbl[w_retIdx];

  if (NumSlots == 2 ** IdxWidth) begin : g_fullRange
    assign w_retInRange = 1'b1;
  end else begin : g_partRange
    assign w_retInRange = (w_retIdx < idx_t'(NumSlots));
  end

  // A held slot that emptied meanwhile is simply re-allocated, so only a foreign owner
  // or a full counter can stall it. With no slot at all nothing is held.
  always_comb begin
    w_selIdx = r_heldIdx;
    w_stall  = 1'b0;
    w_noSlot = 1'b0;
    if (r_pending) begin
      w_stall = w_heldSlot.valid &&
                (w_heldSlot.slv_id != ax_id_i || w_heldSlot.cnt == CntWidth'(MaxTxnsPerId));
    end else if (w_hit.found) begin
      w_selIdx = w_hit.idx;
      w_stall  = (r_tbl[w_hit.idx].cnt == CntWidth'(MaxTxnsPerId));
    end else if (w_free.found) begin
      w_selIdx = w_free.idx;
    end else begin
      w_selIdx = '0;
      w_stall  = 1'b1;
      w_noSlot = 1'b1;
    end
  end

  assign w_hs     = ax_valid_i && ax_ready_i && !w_stall;
  assign w_retOk  = retire_i && w_retInRange && w_retSlot.valid && (w_retSlot.cnt != '0);
  assign stall_o  = w_stall;
  assign mst_id_o = MstIdWidth'(w_selIdx);
  assign slv_id_o = w_retSlot.slv_id;

  always_comb begin
    w_nextTbl = r_tbl;
    if (w_hs) begin
      w_nextTbl[w_selIdx].valid  = 1'b1;
      w_nextTbl[w_selIdx].slv_id = ax_id_i;
      w_nextTbl[w_selIdx].cnt    = r_tbl[w_selIdx].cnt + CntWidth'(1);
    end
    if (w_retOk) begin
      if (w_hs && w_selIdx == w_retIdx) begin
        w_nextTbl[w_retIdx].cnt = r_tbl[w_retIdx].cnt;
      end else begin
        w_nextTbl[w_retIdx].cnt = r_tbl[w_retIdx].cnt - CntWidth'(1);
        if (r_tbl[w_retIdx].cnt == CntWidth'(1)) w_nextTbl[w_retIdx].valid = 1'b0;
      end
    end
  end

  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < NumSlots; i++) begin
      if (r_tbl[i].valid) empty_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) r_tbl[i] <= '0;
      r_pending <= 1'b0;
      r_heldIdx <= '0;
    end else begin
      r_tbl     <= w_nextTbl;
      r_pending <= ax_valid_i && !w_hs && !w_noSlot;
      r_heldIdx <= w_selIdx;
    end
  end

  a_idStable : assert property (@(posedge clk_i) disable iff (rst_i)
    (ax_valid_i && !w_hs && !w_noSlot) |=> (!ax_valid_i || mst_id_o == $past(mst_id_o)));

  a_retireValid : assert property (@(posedge clk_i) disable iff (rst_i)
    retire_i |-> (w_retInRange && w_retSlot.valid && w_retSlot.cnt != '0));

endmodule

// File: rtl/axi_id_remap_ctrl.sv
// ID remap controller: independent write (AW/B) and read (AR/R) mapping tables.
module axi_id_remap_ctrl
  import axi_id_remap_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  aw_valid_i,
  input  logic                  aw_ready_i,
  input  logic [SlvIdWidth-1:0] aw_id_i,
  output logic                  aw_stall_o,
  output logic [MstIdWidth-1:0] mst_aw_id_o,
  input  logic                  b_valid_i,
  input  logic                  b_ready_i,
  input  logic [MstIdWidth-1:0] b_id_i,
  output logic [SlvIdWidth-1:0] slv_b_id_o,
  input  logic                  ar_valid_i,
  input  logic                  ar_ready_i,
  input  logic [SlvIdWidth-1:0] ar_id_i,
  output logic                  ar_stall_o,
  output logic [MstIdWidth-1:0] mst_ar_id_o,
  input  logic                  r_valid_i,
  input  logic                  r_ready_i,
  input  logic                  r_last_i,
  input  logic [MstIdWidth-1:0] r_id_i,
  output logic [SlvIdWidth-1:0] slv_r_id_o,
  output logic                  idle_o
);

  if (NumSlots < 1 || NumSlots > 2 ** MstIdWidth) begin : g_badNumSlots
    $error("NumSlots must lie in 1..2**MstIdWidth");
  end
  if (MaxTxnsPerId < 1) begin : g_badMaxTxns
    $error("MaxTxnsPerId must be at least 1");
  end

  logic w_bFire;
  logic w_rFire;
  logic w_awEmpty;
  logic w_arEmpty;

  // A read slot is only released by the final beat of its burst.
  assign w_bFire = b_valid_i && b_ready_i;
  assign w_rFire = r_valid_i && r_ready_i && r_last_i;
  assign idle_o  = w_awEmpty && w_arEmpty;

  axi_id_remap_table u_wrTable (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ax_valid_i  (aw_valid_i),
    .ax_ready_i  (aw_ready_i),
    .ax_id_i     (aw_id_i),
    .stall_o     (aw_stall_o),
    .mst_id_o    (mst_aw_id_o),
    .retire_i    (w_bFire),
    .retire_id_i (b_id_i),
    .slv_id_o    (slv_b_id_o),
    .empty_o     (w_awEmpty)
  );

  axi_id_remap_table u_rdTable (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ax_valid_i  (ar_valid_i),
    .ax_ready_i  (ar_ready_i),
    .ax_id_i     (ar_id_i),
    .stall_o     (ar_stall_o),
    .mst_id_o    (mst_ar_id_o),
    .retire_i    (w_rFire),
    .retire_id_i (r_id_i),
    .slv_id_o    (slv_r_id_o),
    .empty_o     (w_arEmpty)
  );

endmodule

// File: tb/tb_axi_id_remap_ctrl.sv
// Scoreboard bench for axi_id_remap_ctrl: expected ids are queued when requests and
// responses are driven and compared when the handshake is seen.
module tb_axi_id_remap_ctrl;
  import axi_id_remap_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  aw_valid_i = 1'b0, aw_ready_i = 1'b0;
  logic [SlvIdWidth-1:0] aw_id_i = '0;
  logic                  aw_stall_o;
  logic [MstIdWidth-1:0] mst_aw_id_o;
  logic                  b_valid_i = 1'b0, b_ready_i = 1'b0;
  logic [MstIdWidth-1:0] b_id_i = '0;
  logic [SlvIdWidth-1:0] slv_b_id_o;
  logic                  ar_valid_i = 1'b0, ar_ready_i = 1'b0;
  logic [SlvIdWidth-1:0] ar_id_i = '0;
  logic                  ar_stall_o;
  logic [MstIdWidth-1:0] mst_ar_id_o;
  logic                  r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
  logic [MstIdWidth-1:0] r_id_i = '0;
  logic [SlvIdWidth-1:0] slv_r_id_o;
  logic                  idle_o;

  int checks = 0;
  int errors = 0;
  int expAw[$];
  int expAr[$];
  int expB[$];
  int expR[$];

  axi_id_remap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_id_i(aw_id_i),
    .aw_stall_o(aw_stall_o), .mst_aw_id_o(mst_aw_id_o),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i), .slv_b_id_o(slv_b_id_o),
    .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i),
    .ar_stall_o(ar_stall_o), .mst_ar_id_o(mst_ar_id_o),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_id_i(r_id_i),
    .slv_r_id_o(slv_r_id_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one AW (isRead=0) or AR (isRead=1) request and wait for its handshake.
  task automatic applyStimulus(input bit isRead, input logic [7:0] id, input int expIdx);
    bit done = 1'b0;
    if (isRead) begin
      ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = id; expAr.push_back(expIdx);
    end else begin
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = id; expAw.push_back(expIdx);
    end
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk_i);
      done = isRead ? (ar_valid_i && ar_ready_i && !ar_stall_o)
                    : (aw_valid_i && aw_ready_i && !aw_stall_o);
    end
    if (!done) checkOutput(isRead ? "arTimeout" : "awTimeout", 0, 1);
    tick();
    if (isRead) begin ar_valid_i = 1'b0; ar_ready_i = 1'b0; end
    else begin aw_valid_i = 1'b0; aw_ready_i = 1'b0; end
  endtask

  // Present a request without ready and check which slot it would be given.
  task automatic peekId(input bit isRead, input logic [7:0] id, input int expIdx, input string tag);
    if (isRead) begin ar_valid_i = 1'b1; ar_ready_i = 1'b0; ar_id_i = id; end
    else begin aw_valid_i = 1'b1; aw_ready_i = 1'b0; aw_id_i = id; end
    #1;
    checkOutput(tag, isRead ? int'(mst_ar_id_o) : int'(mst_aw_id_o), expIdx);
    tick();
    ar_valid_i = 1'b0; aw_valid_i = 1'b0;
    tick();
  endtask

  task automatic bSend(input int id, input int expSlv);
    b_valid_i = 1'b1; b_ready_i = 1'b1; b_id_i = MstIdWidth'(id);
    expB.push_back(expSlv);
    tick();
    b_valid_i = 1'b0; b_ready_i = 1'b0;
  endtask

  task automatic rBeat(input int id, input bit last, input int expSlv);
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = last; r_id_i = MstIdWidth'(id);
    expR.push_back(expSlv);
    tick();
    r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
  endtask

  // Scoreboard side: pop one expectation per observed handshake.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (aw_valid_i && aw_ready_i && !aw_stall_o) begin
        if (expAw.size() == 0) checkOutput("awUnexpected", 1, 0);
        else checkOutput("awMstId", int'(mst_aw_id_o), expAw.pop_front());
      end
      if (ar_valid_i && ar_ready_i && !ar_stall_o) begin
        if (expAr.size() == 0) checkOutput("arUnexpected", 1, 0);
        else checkOutput("arMstId", int'(mst_ar_id_o), expAr.pop_front());
      end
      if (b_valid_i && b_ready_i) begin
        if (expB.size() == 0) checkOutput("bUnexpected", 1, 0);
        else checkOutput("bSlvId", int'(slv_b_id_o), expB.pop_front());
      end
      if (r_valid_i && r_ready_i) begin
        if (expR.size() == 0) checkOutput("rUnexpected", 1, 0);
        else checkOutput("rSlvId", int'(slv_r_id_o), expR.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkOutput("rstIdle", idle_o, 1);
    checkOutput("rstAwStall", aw_stall_o, 0);
    checkOutput("rstArStall", ar_stall_o, 0);
    checkOutput("rstMstAw", mst_aw_id_o, 0);
    checkOutput("rstMstAr", mst_ar_id_o, 0);

    $display("[TB] single write and response");
    applyStimulus(0, 8'h3A, 0);
    checkOutput("busyAfterAw", idle_o, 0);
    bSend(0, 8'h3A);
    checkOutput("idleAfterB", idle_o, 1);

    $display("[TB] repeated id shares a slot");
    applyStimulus(0, 8'h10, 0);
    applyStimulus(0, 8'h20, 1);
    applyStimulus(0, 8'h10, 0);
    bSend(0, 8'h10);
    peekId(0, 8'h40, 2, "slot0StillHeld");
    bSend(0, 8'h10);
    applyStimulus(0, 8'h40, 0);
    bSend(0, 8'h40);
    bSend(1, 8'h20);
    checkOutput("idleAfterShare", idle_o, 1);

    $display("[TB] per-id outstanding limit");
    for (int i = 0; i < MaxTxnsPerId; i++) applyStimulus(0, 8'h55, 0);
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = 8'h55; expAw.push_back(0);
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("limitStall", aw_stall_o, 1);
    end
    tick();
    bSend(0, 8'h55);
    @(negedge clk_i);
    checkOutput("limitRelease", aw_stall_o, 0);
    tick();
    aw_valid_i = 1'b0; aw_ready_i = 1'b0;
    checkOutput("limitQueueDrained", expAw.size(), 0);
    for (int i = 0; i < MaxTxnsPerId; i++) bSend(0, 8'h55);
    checkOutput("idleAfterLimit", idle_o, 1);

    $display("[TB] table full");
    for (int i = 0; i < NumSlots; i++) applyStimulus(0, 8'(8'h80 + i), i);
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = 8'hF0;
    @(negedge clk_i);
    checkOutput("fullStall", aw_stall_o, 1);
    tick();
    aw_valid_i = 1'b0; aw_ready_i = 1'b0;
    tick();
    applyStimulus(0, 8'h83, 3);
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = 8'hF0; expAw.push_back(5);
    @(negedge clk_i);
    checkOutput("fullStallAgain", aw_stall_o, 1);
    tick();
    bSend(5, 8'h85);
    @(negedge clk_i);
    checkOutput("freedSlotGrant", aw_stall_o, 0);
    tick();
    aw_valid_i = 1'b0; aw_ready_i = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      bSend(i, (i == 5) ? 8'hF0 : 8'h80 + i);
      if (i == 3) bSend(3, 8'h83);
    end
    checkOutput("idleAfterFull", idle_o, 1);

    $display("[TB] read burst");
    applyStimulus(1, 8'h07, 0);
    repeat (3) rBeat(0, 1'b0, 8'h07);
    checkOutput("burstBusy", idle_o, 0);
    peekId(1, 8'h09, 1, "burstSlotHeld");
    rBeat(0, 1'b1, 8'h07);
    checkOutput("idleAfterBurst", idle_o, 1);

    $display("[TB] held id stability");
    applyStimulus(0, 8'hA0, 0);
    applyStimulus(0, 8'hA1, 1);
    applyStimulus(0, 8'hA2, 2);
    bSend(0, 8'hA0);
    aw_valid_i = 1'b1; aw_ready_i = 1'b0; aw_id_i = 8'hA2;
    @(negedge clk_i);
    checkOutput("holdId0", mst_aw_id_o, 2);
    tick();
    bSend(2, 8'hA2);
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("holdIdStable", mst_aw_id_o, 2);
      tick();
    end
    aw_ready_i = 1'b1; expAw.push_back(2);
    tick();
    aw_valid_i = 1'b0; aw_ready_i = 1'b0;

    $display("[TB] same-cycle retire and allocate");
    applyStimulus(0, 8'hB0, 0);
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = 8'hB0; expAw.push_back(0);
    b_valid_i = 1'b1; b_ready_i = 1'b1; b_id_i = 4'd0; expB.push_back(8'hB0);
    tick();
    aw_valid_i = 1'b0; aw_ready_i = 1'b0; b_valid_i = 1'b0; b_ready_i = 1'b0;
    bSend(0, 8'hB0);
    peekId(0, 8'hC0, 0, "slot0FreedOnce");

    $display("[TB] reset mid-traffic");
    applyStimulus(1, 8'h11, 0);
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = 8'hD0;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0; aw_valid_i = 1'b0; aw_ready_i = 1'b0;
    b_id_i = 4'd2; r_id_i = 4'd0;
    #1;
    checkOutput("midRstIdle", idle_o, 1);
    checkOutput("midRstMstAw", mst_aw_id_o, 0);
    checkOutput("midRstMstAr", mst_ar_id_o, 0);
    checkOutput("midRstSlvB", slv_b_id_o, 0);
    checkOutput("midRstSlvR", slv_r_id_o, 0);
    checkOutput("midRstStall", aw_stall_o, 0);

    checkOutput("awQueueLeft", expAw.size(), 0);
    checkOutput("arQueueLeft", expAr.size(), 0);
    checkOutput("bQueueLeft", expB.size(), 0);
    checkOutput("rQueueLeft", expR.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
